ram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data RAM.
- Shares the RAM between the multicycle processor (port 0) and a second master (port 1), e.g. an I/O loader or a debug/display reader.
- Serialises accesses and guarantees the RAM write strobe (`ram_readwriteN` = 0) is asserted for exactly one cycle per write.
- Returns read data and a one-cycle ack to the owning requester.

---
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter and sequencer for a single-port RAM: serialises accesses,
// drives a one-cycle write strobe and returns a registered ack and read data.
module ram_arbiter #(
    parameter int DW             = 8,
    parameter int AW             = 8,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          ram_readwriteN,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state, state_next;

    logic eff0;
    logic eff1;
    logic grant;
    logic win;
    logic last_owner;
    logic rw_p1;
    logic capture;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A port is masked during its own ack cycle so a held req cannot replay the transaction.
    always_comb begin
        eff0       = req0 & ~ack0;
        eff1       = req1 & ~ack1;
        grant      = 1'b0;
        win        = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (eff0 | eff1) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                    if (eff0 & eff1) begin
                        win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_owner;
                    end else begin
                        win = eff1;
                    end
                end
            end
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        capture = (state == CAPTURE);
    end

    // Grant edge: latch the winner's request onto the RAM bus registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ram_readwriteN <= 1'b1;
            ram_address    <= '0;
            ram_data_in    <= '0;
            rw_p1          <= 1'b1;
            owner          <= 1'b0;
            last_owner     <= 1'b1;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (grant) begin
                owner          <= win;
                last_owner     <= win;
                rw_p1          <= win ? rw1 : rw0;
                ram_readwriteN <= win ? rw1 : rw0;
                ram_address    <= win ? addr1 : addr0;
                ram_data_in    <= win ? wdata1 : wdata0;
            end else if (state == ACCESS) begin
                ram_readwriteN <= 1'b1;
            end
            // Capture edge: RAM read data is valid one cycle after the address.
            if (capture) begin
                if (owner) begin
                    ack1 <= 1'b1;
                    if (rw_p1) begin
                        rdata1 <= ram_data_out;
                    end
                end else begin
                    ack0 <= 1'b1;
                    if (rw_p1) begin
                        rdata0 <= ram_data_out;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a cycle-count transaction model predicts acks, strobes, bus values and read data.
module tb_ram_arbiter;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic [1:0] req    = 2'b00;
    logic [1:0] rw     = 2'b11;
    logic [7:0] addr [2];
    logic [7:0] wdata[2];

    logic       ack0, ack1, ram_readwriteN, busy, owner;
    logic [7:0] rdata0, rdata1, ram_address, ram_data_in, ram_data_out;
    logic       ack0_f, ack1_f, rwn_f, busy_f, owner_f;
    logic [7:0] rdata0_f, rdata1_f, addr_f, din_f;
    logic [7:0] rd_f = 8'h00;

    logic [7:0] mem[256];
    logic       mem_init = 1'b1;

    int checks = 0;
    int errors = 0;

    // transaction-level reference model state
    int         n         = 0;
    int         acc_cyc   = -10;
    int         idle_from = 0;
    int         ack_at[2] = '{-10, -10};
    bit         last      = 1'b1;
    bit         granted[2];
    bit         cur_rw    = 1'b1;
    bit         cur_own   = 1'b0;
    logic [7:0] cur_addr, cur_wdata, txn_rd;
    logic [7:0] shadow[256];
    logic [7:0] mrd[2];
    bit         e_ack[2];
    bit         e_busy, e_rwn;

    always #5 clk = ~clk;

    ram_arbiter #(.DW(8), .AW(8), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .resetN(resetN),
        .req0(req[0]), .rw0(rw[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0), .rdata0(rdata0),
        .req1(req[1]), .rw1(rw[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1), .rdata1(rdata1),
        .ram_readwriteN(ram_readwriteN), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .busy(busy), .owner(owner)
    );

    ram_arbiter #(.DW(8), .AW(8), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .resetN(resetN),
        .req0(req[0]), .rw0(rw[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0_f), .rdata0(rdata0_f),
        .req1(req[1]), .rw1(rw[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1_f), .rdata1(rdata1_f),
        .ram_readwriteN(rwn_f), .ram_address(addr_f), .ram_data_in(din_f),
        .ram_data_out(rd_f), .busy(busy_f), .owner(owner_f)
    );

    // RAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (!ram_readwriteN) begin
            mem[ram_address] <= ram_data_in;
        end
        ram_data_out <= mem[ram_address];
    end

    task automatic model_reset();
        acc_cyc    = -10;
        idle_from  = n;
        ack_at[0]  = -10;
        ack_at[1]  = -10;
        last       = 1'b1;
        cur_rw     = 1'b1;
        cur_own    = 1'b0;
        granted[0] = 1'b0;
        granted[1] = 1'b0;
        mrd[0]     = 8'h00;
        mrd[1]     = 8'h00;
    endtask

    // Move to mid-cycle n and compute the expected outputs for that cycle.
    task automatic settle();
        @(negedge clk);
        if (n == acc_cyc + 1) begin
            if (cur_rw) txn_rd = shadow[cur_addr];
            else        shadow[cur_addr] = cur_wdata;
        end
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = (ack_at[i] == n);
            if (e_ack[i]) begin
                granted[i] = 1'b0;
                if (cur_rw) mrd[i] = txn_rd;
            end
        end
        e_busy = (n == acc_cyc) || (n == acc_cyc + 1);
        e_rwn  = !((n == acc_cyc) && !cur_rw);
    endtask

    // Apply the arbitration rule to this cycle's inputs, then advance to the next cycle.
    task automatic next();
        bit eff[2];
        int w;
        for (int i = 0; i < 2; i++) eff[i] = req[i] && (ack_at[i] != n);
        if (n >= idle_from && (eff[0] || eff[1])) begin
            if (eff[0] && eff[1]) w = last ? 0 : 1;
            else                  w = eff[1] ? 1 : 0;
            cur_own   = w[0];
            last      = w[0];
            cur_rw    = rw[w];
            cur_addr  = addr[w];
            cur_wdata = wdata[w];
            acc_cyc   = n + 1;
            ack_at[w] = n + 3;
            idle_from = n + 3;
            granted[w] = 1'b1;
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        req    = 2'b00;
        resetN = 1'b0;
        @(posedge clk); #1; n++;
        @(posedge clk); #1; n++;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (ram_readwriteN !== 1'b1) begin errors++; $display("FAIL rst_rwn: got %b expected 1", ram_readwriteN); end
        checks++; if (ram_address !== 8'h00 || ram_data_in !== 8'h00) begin errors++; $display("FAIL rst_bus: got %h %h expected 00 00", ram_address, ram_data_in); end
        checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b%b expected 00", ack0, ack1); end
        checks++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h %h expected 00 00", rdata0, rdata1); end
        checks++; if (busy !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL rst_busy_owner: got %b %b expected 0 0", busy, owner); end
        checks++; if (rwn_f !== 1'b1 || busy_f !== 1'b0) begin errors++; $display("FAIL rst_fp: got rwn %b busy %b expected 1 0", rwn_f, busy_f); end
        resetN   = 1'b1;
        mem_init = 1'b0;
        n        = 0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (busy !== e_busy || ack0 !== e_ack[0]) begin errors++; $display("FAIL rst_idle cyc %0d: got busy %b ack0 %b expected %b %b", n, busy, ack0, e_busy, e_ack[0]); end
            next();
        end
    endtask

    task automatic test_single_write();
        int start   = n;
        int strobes = 0;
        int n_ack0  = 0;
        int n_ack1  = 0;
        int ack_off = -1;
        int stb_off = -1;
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h10; wdata[0] = 8'h3C;
        for (int k = 0; k < 7; k++) begin
            settle();
            if (!ram_readwriteN) begin
                strobes++;
                stb_off = n - start;
                checks++; if (ram_address !== 8'h10 || ram_data_in !== 8'h3C) begin errors++; $display("FAIL wr_bus: got %h %h expected 10 3c", ram_address, ram_data_in); end
            end
            checks++; if (ram_readwriteN !== e_rwn) begin errors++; $display("FAIL wr_rwn cyc %0d: got %b expected %b", n, ram_readwriteN, e_rwn); end
            checks++; if (ack0 !== e_ack[0]) begin errors++; $display("FAIL wr_ack0 cyc %0d: got %b expected %b", n, ack0, e_ack[0]); end
            if (ack0) begin n_ack0++; ack_off = n - start; end
            if (ack1) n_ack1++;
            if (e_ack[0]) req[0] = 1'b0;
            next();
        end
        checks++; if (strobes !== 1 || stb_off !== 1) begin errors++; $display("FAIL wr_strobe: got %0d strobes at %0d expected 1 at 1", strobes, stb_off); end
        checks++; if (n_ack0 !== 1 || ack_off !== 3) begin errors++; $display("FAIL wr_ack_lat: got %0d acks at %0d expected 1 at 3", n_ack0, ack_off); end
        checks++; if (n_ack1 !== 0) begin errors++; $display("FAIL wr_ack1: got %0d expected 0", n_ack1); end
    endtask

    task automatic test_single_read();
        int start   = n;
        int strobes = 0;
        int ack_off = -1;
        req[1] = 1'b1; rw[1] = 1'b1; addr[1] = 8'h10; wdata[1] = 8'hEE;
        for (int k = 0; k < 7; k++) begin
            settle();
            if (!ram_readwriteN) strobes++;
            checks++; if (ack1 !== e_ack[1]) begin errors++; $display("FAIL rd_ack1 cyc %0d: got %b expected %b", n, ack1, e_ack[1]); end
            if (e_busy) begin
                checks++; if (owner !== 1'b1 || ram_address !== 8'h10) begin errors++; $display("FAIL rd_bus: got owner %b addr %h expected 1 10", owner, ram_address); end
            end
            if (ack1) ack_off = n - start;
            if (e_ack[1]) req[1] = 1'b0;
            next();
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL rd_strobe: got %0d expected 0", strobes); end
        checks++; if (ack_off !== 3) begin errors++; $display("FAIL rd_ack_lat: got %0d expected 3", ack_off); end
        checks++; if (rdata1 !== 8'h3C) begin errors++; $display("FAIL rd_data: got %h expected 3c", rdata1); end
    endtask

    task automatic test_round_robin();
        int got_p[$];
        int got_c[$];
        int exp_p[3] = '{0, 1, 0};
        int exp_c[3] = '{3, 6, 9};
        int macks    = 0;
        int start;
        do_reset();
        start = n;
        req = 2'b11; rw = 2'b11; addr[0] = 8'h30; addr[1] = 8'h31;
        for (int k = 0; k < 13; k++) begin
            settle();
            checks++; if (ack0 !== e_ack[0] || ack1 !== e_ack[1]) begin errors++; $display("FAIL rr_ack cyc %0d: got %b%b expected %b%b", n, ack1, ack0, e_ack[1], e_ack[0]); end
            if (ack0) begin got_p.push_back(0); got_c.push_back(n - start); end
            if (ack1) begin got_p.push_back(1); got_c.push_back(n - start); end
            if (e_ack[0] || e_ack[1]) macks++;
            if (macks == 3) req = 2'b00;
            next();
        end
        checks++; if (got_p.size() !== 3) begin errors++; $display("FAIL rr_count: got %0d expected 3", got_p.size()); end
        for (int i = 0; i < 3 && i < got_p.size(); i++) begin
            checks++; if (got_p[i] !== exp_p[i] || got_c[i] !== exp_c[i]) begin errors++; $display("FAIL rr_order %0d: got port %0d at %0d expected port %0d at %0d", i, got_p[i], got_c[i], exp_p[i], exp_c[i]); end
        end
        checks++; if (rdata0 !== 8'h6A || rdata1 !== 8'h6B) begin errors++; $display("FAIL rr_data: got %h %h expected 6a 6b", rdata0, rdata1); end
    endtask

    task automatic test_held_mask();
        int acc_a[$];
        int ack_c[$];
        int macks = 0;
        bit chg   = 1'b0;
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h01;
        for (int k = 0; k < 12; k++) begin
            settle();
            checks++; if (ack0 !== e_ack[0]) begin errors++; $display("FAIL hm_ack0 cyc %0d: got %b expected %b", n, ack0, e_ack[0]); end
            if (n == acc_cyc) acc_a.push_back(int'(ram_address));
            if (ack0) ack_c.push_back(n);
            if (e_ack[0]) begin
                macks++;
                if (macks == 1) chg = 1'b1;
                if (macks == 2) req[0] = 1'b0;
            end
            next();
            if (chg) begin addr[0] = 8'h02; chg = 1'b0; end
        end
        checks++; if (acc_a.size() !== 2) begin errors++; $display("FAIL hm_count: got %0d expected 2", acc_a.size()); end
        if (acc_a.size() == 2) begin
            checks++; if (acc_a[0] !== 1 || acc_a[1] !== 2) begin errors++; $display("FAIL hm_addr: got %0h %0h expected 1 2", acc_a[0], acc_a[1]); end
        end
        checks++; if (ack_c.size() !== 2) begin errors++; $display("FAIL hm_acks: got %0d expected 2", ack_c.size()); end
        else begin
            checks++; if (ack_c[1] - ack_c[0] !== 4) begin errors++; $display("FAIL hm_gap: got %0d expected 4", ack_c[1] - ack_c[0]); end
        end
        checks++; if (rdata0 !== 8'h58) begin errors++; $display("FAIL hm_data: got %h expected 58", rdata0); end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] saved;
        saved = mem[8'h20];
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h20; wdata[0] = 8'hAA;
        settle();
        next();
        req[0] = 1'b0;
        #1;
        checks++; if (ram_readwriteN !== 1'b0) begin errors++; $display("FAIL rmw_strobe: got %b expected 0", ram_readwriteN); end
        resetN = 1'b0;
        #1;
        checks++; if (ram_readwriteN !== 1'b1) begin errors++; $display("FAIL rmw_rwn: got %b expected 1", ram_readwriteN); end
        checks++; if (busy !== 1'b0 || owner !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL rmw_ctrl: got %b %b %b %b expected 0 0 0 0", busy, owner, ack0, ack1); end
        checks++; if (ram_address !== 8'h00 || ram_data_in !== 8'h00 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin errors++; $display("FAIL rmw_data: got %h %h %h %h expected 00", ram_address, ram_data_in, rdata0, rdata1); end
        @(posedge clk); #1; n++;
        resetN = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++; if (ack0 !== e_ack[0] || ram_readwriteN !== e_rwn) begin errors++; $display("FAIL rmw_after cyc %0d: got ack0 %b rwn %b expected %b %b", n, ack0, ram_readwriteN, e_ack[0], e_rwn); end
            next();
        end
        checks++; if (mem[8'h20] !== saved) begin errors++; $display("FAIL rmw_mem: got %h expected %h", mem[8'h20], saved); end
    endtask

    task automatic test_fixed_priority();
        int t;
        do_reset();
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h40;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++; if (ack0_f !== e_ack[0] || ack0 !== e_ack[0]) begin errors++; $display("FAIL fp_solo cyc %0d: got %b %b expected %b", n, ack0, ack0_f, e_ack[0]); end
            if (e_ack[0]) req[0] = 1'b0;
            next();
        end
        t = n;
        req = 2'b11; rw = 2'b11; addr[0] = 8'h42; addr[1] = 8'h41;
        for (int k = 0; k < 9; k++) begin
            settle();
            checks++; if (ack0 !== e_ack[0] || ack1 !== e_ack[1]) begin errors++; $display("FAIL fp_rr cyc %0d: got %b%b expected %b%b", n, ack1, ack0, e_ack[1], e_ack[0]); end
            checks++; if (ack0_f !== (n == t + 3) || ack1_f !== (n == t + 6)) begin errors++; $display("FAIL fp_fixed cyc %0d: got %b%b expected %b%b", n - t, ack1_f, ack0_f, (n == t + 6), (n == t + 3)); end
            if (n == t + 3) req[0] = 1'b0;
            if (n == t + 6) req[1] = 1'b0;
            next();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (k >= 590) begin
                    if (!granted[i]) req[i] = 1'b0;
                end else if (ack_at[i] == n) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else begin rw[i] = 1'($urandom_range(0, 1)); addr[i] = 8'($urandom_range(0, 15)); wdata[i] = 8'($urandom); end
                end else if (granted[i]) begin
                    addr[i] = 8'($urandom); wdata[i] = 8'($urandom);
                end else if (req[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1; rw[i] = 1'($urandom_range(0, 1));
                    addr[i] = 8'($urandom_range(0, 15)); wdata[i] = 8'($urandom);
                end
            end
            settle();
            checks++; if (ack0 !== e_ack[0] || ack1 !== e_ack[1]) begin errors++; $display("FAIL rnd_ack cyc %0d: got %b%b expected %b%b", n, ack1, ack0, e_ack[1], e_ack[0]); end
            checks++; if (busy !== e_busy || ram_readwriteN !== e_rwn) begin errors++; $display("FAIL rnd_ctrl cyc %0d: got busy %b rwn %b expected %b %b", n, busy, ram_readwriteN, e_busy, e_rwn); end
            checks++; if (rdata0 !== mrd[0] || rdata1 !== mrd[1]) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %h %h expected %h %h", n, rdata0, rdata1, mrd[0], mrd[1]); end
            if (e_busy) begin
                checks++; if (owner !== cur_own || ram_address !== cur_addr) begin errors++; $display("FAIL rnd_bus cyc %0d: got owner %b addr %h expected %b %h", n, owner, ram_address, cur_own, cur_addr); end
            end
            if (n == acc_cyc) begin
                checks++; if (ram_data_in !== cur_wdata) begin errors++; $display("FAIL rnd_wdata cyc %0d: got %h expected %h", n, ram_data_in, cur_wdata); end
            end
            next();
        end
    endtask

    initial begin
        addr[0] = 8'h00; addr[1] = 8'h00; wdata[0] = 8'h00; wdata[1] = 8'h00;
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_held_mask();
        test_reset_mid_write();
        test_fixed_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
